// File: rtl/soc_onchip_memory_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port, byte-enabled,
// clock-enabled on-chip RAM. Round-robin between the CPU data master (m0)
// and the voice engine (m1), with a bounded hold so one master can stream
// back-to-back while the other waits. Read data is routed back by a tag
// pipeline whose depth matches the RAM read latency.
module soc_onchip_memory_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_HOLD   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD - 1);

    logic                  m0_req;
    logic                  m1_req;
    logic                  grant0;
    logic                  grant1;
    logic                  any_grant;
    logic                  rd_accept;
    logic                  last_grant;
    logic                  streak;
    logic [3:0]            hold_cnt;
    logic [RD_LATENCY-1:0] tag_valid;
    logic [RD_LATENCY-1:0] tag_id;
    logic                  out_valid;
    logic                  out_id;
    logic [DATA_W-1:0]     m0_rd_q;
    logic [DATA_W-1:0]     m1_rd_q;

    assign m0_req = m0_read | m0_write;
    assign m1_req = m1_read | m1_write;

    // Pick at most one master per cycle. The previous winner may keep the
    // RAM only while its run of back-to-back grants is unbroken (streak) and
    // shorter than MAX_HOLD; after reset or an idle cycle the contest is
    // pure round-robin, which is what lets m0 win the first contest.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (m0_req && !m1_req) begin
            grant0 = 1'b1;
        end else if (m1_req && !m0_req) begin
            grant1 = 1'b1;
        end else if (m0_req && m1_req) begin
            if (streak && (hold_cnt < HOLD_LIM)) begin
                grant0 = ~last_grant;
                grant1 = last_grant;
            end else begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end
        end
    end

    assign any_grant      = grant0 | grant1;
    assign m0_waitrequest = m0_req & ~grant0;
    assign m1_waitrequest = m1_req & ~grant1;

    // Read+write together counts as a write and never returns data.
    assign rd_accept = (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);

    assign mem_address    = grant1 ? m1_address    : m0_address;
    assign mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = grant1 ? m1_writedata  : m0_writedata;
    assign mem_chipselect = any_grant;
    assign mem_write      = (grant0 & m0_write) | (grant1 & m1_write);
    assign mem_clken      = 1'b1;

    // Arbitration history: last winner, whether it won the previous cycle,
    // and how many extra consecutive grants it has had (saturating).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            streak     <= 1'b0;
            hold_cnt   <= 4'd0;
        end else if (any_grant) begin
            last_grant <= grant1;
            streak     <= 1'b1;
            if (streak && (grant1 == last_grant)) begin
                hold_cnt <= (hold_cnt < HOLD_LIM) ? hold_cnt + 4'd1 : HOLD_LIM;
            end else begin
                hold_cnt <= 4'd0;
            end
        end else begin
            streak   <= 1'b0;
            hold_cnt <= 4'd0;
        end
    end

    // Read tag shift register, one stage per cycle of RAM read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid <= '0;
            tag_id    <= '0;
        end else begin
            tag_valid[0] <= rd_accept;
            tag_id[0]    <= grant1;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    assign out_valid        = tag_valid[RD_LATENCY-1];
    assign out_id           = tag_id[RD_LATENCY-1];
    assign m0_readdatavalid = out_valid & ~out_id;
    assign m1_readdatavalid = out_valid & out_id;
    assign m0_readdata      = m0_readdatavalid ? mem_readdata : m0_rd_q;
    assign m1_readdata      = m1_readdatavalid ? mem_readdata : m1_rd_q;

    // Remember the last word delivered to each master so its readdata holds
    // steady while the other master is being served.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0_rd_q <= '0;
            m1_rd_q <= '0;
        end else begin
            if (m0_readdatavalid) m0_rd_q <= mem_readdata;
            if (m1_readdatavalid) m1_rd_q <= mem_readdata;
        end
    end

endmodule

// File: tb/tb_soc_onchip_memory_arbiter.sv
// Bench for soc_onchip_memory_arbiter: a latency-1 and a latency-2 instance
// share the same master stimulus, each with its own behavioural RAM.
module tb_soc_onchip_memory_arbiter;

    localparam int MH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [7:0]  m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] m0_writedata, m1_writedata;

    logic        a_w0, a_w1, a_v0, a_v1, a_cs, a_wr, a_ck;
    logic [31:0] a_d0, a_d1, a_wd, a_rd;
    logic [7:0]  a_ad;
    logic [3:0]  a_be;
    logic        b_w0, b_w1, b_v0, b_v1, b_cs, b_wr, b_ck;
    logic [31:0] b_d0, b_d1, b_wd, b_rd;
    logic [7:0]  b_ad;
    logic [3:0]  b_be;

    logic [31:0] ram_a [256];
    logic [31:0] ram_b [256];
    logic [31:0] b_q1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    soc_onchip_memory_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LATENCY(1), .MAX_HOLD(MH)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(a_w0),
        .m0_readdata(a_d0), .m0_readdatavalid(a_v0),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(a_w1),
        .m1_readdata(a_d1), .m1_readdatavalid(a_v1),
        .mem_address(a_ad), .mem_byteenable(a_be), .mem_chipselect(a_cs),
        .mem_write(a_wr), .mem_writedata(a_wd), .mem_clken(a_ck), .mem_readdata(a_rd)
    );

    soc_onchip_memory_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LATENCY(2), .MAX_HOLD(MH)) u_dut2 (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(b_w0),
        .m0_readdata(b_d0), .m0_readdatavalid(b_v0),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(b_w1),
        .m1_readdata(b_d1), .m1_readdatavalid(b_v1),
        .mem_address(b_ad), .mem_byteenable(b_be), .mem_chipselect(b_cs),
        .mem_write(b_wr), .mem_writedata(b_wd), .mem_clken(b_ck), .mem_readdata(b_rd)
    );

    // Behavioural RAM, 1-cycle read latency
    always @(posedge clk) begin
        if (a_cs && a_ck) begin
            if (a_wr) begin
                for (int b = 0; b < 4; b++)
                    if (a_be[b]) ram_a[a_ad][8*b +: 8] <= a_wd[8*b +: 8];
            end else begin
                a_rd <= ram_a[a_ad];
            end
        end
    end

    // Behavioural RAM, 2-cycle read latency
    always @(posedge clk) begin
        if (b_ck) b_rd <= b_q1;
        if (b_cs && b_ck) begin
            if (b_wr) begin
                for (int b = 0; b < 4; b++)
                    if (b_be[b]) ram_b[b_ad][8*b +: 8] <= b_wd[8*b +: 8];
            end else begin
                b_q1 <= ram_b[b_ad];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        m0_read = 0; m0_write = 0; m0_address = 0; m0_byteenable = 0; m0_writedata = 0;
        m1_read = 0; m1_write = 0; m1_address = 0; m1_byteenable = 0; m1_writedata = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic gen(output logic r, output logic w, output logic [7:0] a,
                       output logic [3:0] be, output logic [31:0] d);
        int k;
        k  = $urandom_range(0, 9);
        r  = (k >= 4 && k <= 6) || (k == 9);
        w  = (k >= 7);
        a  = 8'h80 + 8'($urandom_range(0, 7));
        be = 4'($urandom_range(1, 15));
        d  = $urandom;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    typedef struct {
        logic r0, w0; logic [7:0] a0; logic [3:0] be0; logic [31:0] d0;
        logic r1, w1; logic [7:0] a1; logic [3:0] be1; logic [31:0] d1;
        logic ew0, ew1, ecs;
        logic ev0; logic [31:0] ed0;
        logic ev1; logic [31:0] ed1;
    } vec_t;

    typedef struct { int due; logic id; logic [31:0] data; } pend_t;

    vec_t        tbl [15];
    pend_t       qa [$];
    pend_t       qb [$];
    logic [31:0] shadow [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        st0, st1, req0, req1, g, any, holder, va, vb;
        logic [31:0] h0a, h1a, h0b, h1b;
        int          run;

        tbl[0]  = '{0,1,8'h10,4'hF,32'hDEADBEEF, 0,0,8'h00,4'h0,32'h0, 0,0,1, 0,32'h0,        0,32'h0};
        tbl[1]  = '{1,0,8'h10,4'hF,32'h0,        0,0,8'h00,4'h0,32'h0, 0,0,1, 0,32'h0,        0,32'h0};
        tbl[2]  = '{0,0,8'h00,4'h0,32'h0,        0,0,8'h00,4'h0,32'h0, 0,0,0, 1,32'hDEADBEEF, 0,32'h0};
        tbl[3]  = '{0,1,8'h20,4'hF,32'h11223344, 0,0,8'h00,4'h0,32'h0, 0,0,1, 0,32'hDEADBEEF, 0,32'h0};
        tbl[4]  = '{0,1,8'h20,4'h5,32'hAABBCCDD, 0,0,8'h00,4'h0,32'h0, 0,0,1, 0,32'hDEADBEEF, 0,32'h0};
        tbl[5]  = '{1,0,8'h20,4'hF,32'h0,        0,0,8'h00,4'h0,32'h0, 0,0,1, 0,32'hDEADBEEF, 0,32'h0};
        tbl[6]  = '{0,0,8'h00,4'h0,32'h0,        0,0,8'h00,4'h0,32'h0, 0,0,0, 1,32'h11BB33DD, 0,32'h0};
        tbl[7]  = '{1,0,8'h10,4'hF,32'h0,        1,0,8'h20,4'hF,32'h0, 1,0,1, 0,32'h11BB33DD, 0,32'h0};
        tbl[8]  = '{1,0,8'h10,4'hF,32'h0,        0,0,8'h00,4'h0,32'h0, 0,0,1, 0,32'h11BB33DD, 1,32'h11BB33DD};
        tbl[9]  = '{0,0,8'h00,4'h0,32'h0,        0,1,8'h30,4'hF,32'hCAFEF00D, 0,0,1, 1,32'hDEADBEEF, 0,32'h11BB33DD};
        tbl[10] = '{1,0,8'h30,4'hF,32'h0,        0,0,8'h00,4'h0,32'h0, 0,0,1, 0,32'hDEADBEEF, 0,32'h11BB33DD};
        tbl[11] = '{0,0,8'h00,4'h0,32'h0,        0,0,8'h00,4'h0,32'h0, 0,0,0, 1,32'hCAFEF00D, 0,32'h11BB33DD};
        tbl[12] = '{0,0,8'h00,4'h0,32'h0,        1,1,8'h40,4'hF,32'h12345678, 0,0,1, 0,32'hCAFEF00D, 0,32'h11BB33DD};
        tbl[13] = '{1,0,8'h40,4'hF,32'h0,        0,0,8'h00,4'h0,32'h0, 0,0,1, 0,32'hCAFEF00D, 0,32'h11BB33DD};
        tbl[14] = '{0,0,8'h00,4'h0,32'h0,        0,0,8'h00,4'h0,32'h0, 0,0,0, 1,32'h12345678, 0,32'h11BB33DD};

        // Reset state
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset m0_rdv", a_v0, 0);
        chk("reset m1_rdv", a_v1, 0);
        chk("reset m0_rd", a_d0, 0);
        chk("reset m1_rd", a_d1, 0);
        chk("reset cs", a_cs, 0);
        chk("reset clken", a_ck, 1);
        chk("reset clken2", b_ck, 1);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Directed vector table against the latency-1 instance
        for (int i = 0; i < 15; i++) begin
            m0_read = tbl[i].r0; m0_write = tbl[i].w0; m0_address = tbl[i].a0;
            m0_byteenable = tbl[i].be0; m0_writedata = tbl[i].d0;
            m1_read = tbl[i].r1; m1_write = tbl[i].w1; m1_address = tbl[i].a1;
            m1_byteenable = tbl[i].be1; m1_writedata = tbl[i].d1;
            @(negedge clk);
            chk($sformatf("vec%0d m0_wait", i), a_w0, tbl[i].ew0);
            chk($sformatf("vec%0d m1_wait", i), a_w1, tbl[i].ew1);
            chk($sformatf("vec%0d cs", i), a_cs, tbl[i].ecs);
            chk($sformatf("vec%0d m0_rdv", i), a_v0, tbl[i].ev0);
            chk($sformatf("vec%0d m0_rd", i), a_d0, tbl[i].ed0);
            chk($sformatf("vec%0d m1_rdv", i), a_v1, tbl[i].ev1);
            chk($sformatf("vec%0d m1_rd", i), a_d1, tbl[i].ed1);
            @(posedge clk);
            #1;
        end

        // Reset one cycle after an accepted m1 read: no data may come back
        idle();
        m1_read = 1; m1_address = 8'h10; m1_byteenable = 4'hF;
        @(negedge clk);
        chk("rstmid accept", a_w1, 0);
        @(posedge clk);
        #1 reset_n = 1'b0;
        idle();
        @(negedge clk);
        chk("rstmid m1_rdv", a_v1, 0);
        @(posedge clk);
        @(negedge clk);
        chk("rstmid m1_rdv2", a_v1, 0);
        chk("rstmid lat2 m1_rdv", b_v1, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rstmid m0_rd", a_d0, 0);
        chk("rstmid m1_rd", a_d1, 0);
        chk("rstmid lat2 m1_rd", b_d1, 0);
        @(posedge clk);
        #1;

        // First contest after reset: m0 first, then m1; data tagged per master
        m0_read = 1; m0_address = 8'h10; m0_byteenable = 4'hF;
        m1_read = 1; m1_address = 8'h20; m1_byteenable = 4'hF;
        @(negedge clk);
        chk("contest m0_wait", a_w0, 0);
        chk("contest m1_wait", a_w1, 1);
        chk("contest addr", a_ad, 8'h10);
        @(posedge clk);
        #1 m0_read = 0;
        @(negedge clk);
        chk("contest m1_wait2", a_w1, 0);
        chk("contest addr2", a_ad, 8'h20);
        chk("contest m0_rdv", a_v0, 1);
        chk("contest m0_rd", a_d0, 32'hDEADBEEF);
        chk("contest m1_rdv early", a_v1, 0);
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        chk("contest m1_rdv", a_v1, 1);
        chk("contest m1_rd", a_d1, 32'h11BB33DD);
        chk("contest m0_rdv off", a_v0, 0);
        chk("contest lat2 m0_rdv", b_v0, 1);
        chk("contest lat2 m0_rd", b_d0, 32'hDEADBEEF);
        @(posedge clk);
        @(negedge clk);
        chk("contest lat2 m1_rdv", b_v1, 1);
        chk("contest lat2 m1_rd", b_d1, 32'h11BB33DD);
        chk("contest lat2 m0_rdv off", b_v0, 0);
        @(posedge clk);
        #1;

        // Hold: m1 streams 10 reads, m0 joins for one read from cycle 1
        do_reset();
        begin
            int  m1_done;
            logic m0_done;
            m1_done = 0;
            m0_done = 1'b0;
            for (int c = 0; c < 11; c++) begin
                m1_read = 1; m1_address = 8'h60 + 8'(m1_done); m1_byteenable = 4'hF;
                m0_read = (c >= 1) && !m0_done; m0_address = 8'h50; m0_byteenable = 4'hF;
                @(negedge clk);
                chk($sformatf("hold c%0d m1_wait", c), a_w1, (c == 4));
                chk($sformatf("hold c%0d m0_wait", c), a_w0, (c >= 1 && c <= 3));
                if (c != 4) m1_done++;
                if (c == 4) m0_done = 1'b1;
                @(posedge clk);
                #1;
            end
            idle();
            repeat (3) @(posedge clk);
            #1;
        end

        // Preload the random-test window so RAM and shadow agree
        for (int i = 0; i < 8; i++) begin
            shadow[i] = $urandom;
            m0_write = 1; m0_address = 8'h80 + 8'(i); m0_byteenable = 4'hF; m0_writedata = shadow[i];
            @(posedge clk);
            #1;
        end
        idle();

        // Randomized traffic against a reference model of the arbitration rules
        do_reset();
        holder = 1'b1; run = 0; st0 = 0; st1 = 0;
        h0a = 0; h1a = 0; h0b = 0; h1b = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!st0) gen(m0_read, m0_write, m0_address, m0_byteenable, m0_writedata);
            if (!st1) gen(m1_read, m1_write, m1_address, m1_byteenable, m1_writedata);
            @(negedge clk);
            req0 = m0_read | m0_write;
            req1 = m1_read | m1_write;
            any  = req0 | req1;
            if (req0 && req1) g = (run > 0 && run < MH) ? holder : ~holder;
            else              g = req1;
            chk("rnd m0_wait", a_w0, req0 && (g != 0));
            chk("rnd m1_wait", a_w1, req1 && (g != 1));
            chk("rnd lat2 m0_wait", b_w0, req0 && (g != 0));
            chk("rnd lat2 m1_wait", b_w1, req1 && (g != 1));
            chk("rnd cs", a_cs, any);
            chk("rnd mem_write", a_wr, any && (g ? m1_write : m0_write));
            if (any) chk("rnd addr", a_ad, g ? m1_address : m0_address);

            va = (qa.size() > 0) && (qa[0].due == cyc);
            vb = (qb.size() > 0) && (qb[0].due == cyc);
            if (va) begin
                if (qa[0].id) h1a = qa[0].data; else h0a = qa[0].data;
            end
            if (vb) begin
                if (qb[0].id) h1b = qb[0].data; else h0b = qb[0].data;
            end
            chk("rnd m0_rdv", a_v0, va && !qa[0].id);
            chk("rnd m1_rdv", a_v1, va && qa[0].id);
            chk("rnd m0_rd", a_d0, h0a);
            chk("rnd m1_rd", a_d1, h1a);
            chk("rnd lat2 m0_rdv", b_v0, vb && !qb[0].id);
            chk("rnd lat2 m1_rdv", b_v1, vb && qb[0].id);
            chk("rnd lat2 m0_rd", b_d0, h0b);
            chk("rnd lat2 m1_rd", b_d1, h1b);
            if (va) void'(qa.pop_front());
            if (vb) void'(qb.pop_front());

            if (any) begin
                logic        rd, wr;
                logic [2:0]  idx;
                rd  = g ? (m1_read & ~m1_write) : (m0_read & ~m0_write);
                wr  = g ? m1_write : m0_write;
                idx = g ? m1_address[2:0] : m0_address[2:0];
                if (rd) begin
                    qa.push_back('{cyc + 1, g, shadow[idx]});
                    qb.push_back('{cyc + 2, g, shadow[idx]});
                end
                if (wr) shadow[idx] = merge(shadow[idx], g ? m1_writedata : m0_writedata,
                                            g ? m1_byteenable : m0_byteenable);
                run    = (run > 0 && g == holder) ? run + 1 : 1;
                holder = g;
            end else begin
                run = 0;
            end
            st0 = req0 && (g != 0);
            st1 = req1 && (g != 1);
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
